// File: rtl/riscv_pkg.sv
// Shared RISC-V types used by the atomic sequencer and the LR/SC reservation tracker.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [3:0] {
    AMO_LR,
    AMO_SC,
    AMO_SWAP,
    AMO_ADD,
    AMO_XOR,
    AMO_AND,
    AMO_OR,
    AMO_MIN,
    AMO_MAX,
    AMO_MINU,
    AMO_MAXU
  } amo_op_e;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] address;
    logic               lr_in_flight;
    logic [RV_XLEN-1:0] lr_in_flight_addr;
  } reservation_t;

  function automatic logic same_word(logic [RV_XLEN-1:0] a, logic [RV_XLEN-1:0] b);
    return a[RV_XLEN-1:2] == b[RV_XLEN-1:2];
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write function for AMO*.W: new = f(op, old, rs2).
module amo_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  amo_op_e         op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = old_val;
    case (op)
      AMO_SWAP: result = rs2;
      AMO_ADD:  result = old_val + rs2;
      AMO_XOR:  result = old_val ^ rs2;
      AMO_AND:  result = old_val & rs2;
      AMO_OR:   result = old_val | rs2;
      // strict compares so that ties keep the old value
      AMO_MIN:  result = ($signed(rs2) < $signed(old_val)) ? rs2 : old_val;
      AMO_MAX:  result = ($signed(rs2) > $signed(old_val)) ? rs2 : old_val;
      AMO_MINU: result = (rs2 < old_val) ? rs2 : old_val;
      AMO_MAXU: result = (rs2 > old_val) ? rs2 : old_val;
      default:  result = old_val;
    endcase
  end

endmodule

// File: rtl/amo_unit.sv
// Atomic memory sequencer: runs LR.W / SC.W / AMO*.W against the data port and
// stalls the pipeline until the atomic finishes.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for an atomic in EX
// S_READ_REQ  | read request on the port, waiting for acceptance
// S_READ_WAIT | read accepted, waiting for read data
// S_WRITE_REQ | write request on the port, waiting for acceptance
// S_DONE      | one-cycle result (or misaligned) pulse, pipeline released
module amo_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  amo_op_e         i_op,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  input  reservation_t    i_reservation,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_stall,
  output logic            o_result_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_REQ,
    S_READ_WAIT,
    S_WRITE_REQ,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  amo_op_e           op_q, op_d;
  logic [XLEN-1:2]   word_q, word_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   alu_out;
  logic              sc_hit;
  logic              resv_unused;

  amo_alu #(.XLEN(XLEN)) u_alu (
    .op      (op_q),
    .old_val (i_mem_rdata),
    .rs2     (rs2_q),
    .result  (alu_out)
  );

  assign sc_hit = (i_reservation.valid && same_word(i_reservation.address, i_addr)) ||
                  (i_reservation.lr_in_flight &&
                   same_word(i_reservation.lr_in_flight_addr, i_addr));

  // only the word index of the reservation matters
  assign resv_unused = ^{i_reservation.address[1:0], i_reservation.lr_in_flight_addr[1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= AMO_LR;
      word_q   <= '0;
      rs2_q    <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      rs2_q    <= rs2_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    rs2_d    = rs2_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    mis_d    = mis_q;
    o_stall  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          o_stall  = 1'b1;
          op_d     = i_op;
          word_d   = i_addr[XLEN-1:2];
          rs2_d    = i_rs2_data;
          wdata_d  = '0;
          result_d = '0;
          mis_d    = 1'b0;
          if (i_addr[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else if (i_op == AMO_SC) begin
            if (sc_hit) begin
              wdata_d = i_rs2_data;
              state_d = S_WRITE_REQ;
            end else begin
              result_d = {{(XLEN-1){1'b0}}, 1'b1};
              state_d  = S_DONE;
            end
          end else begin
            state_d = S_READ_REQ;
          end
        end
      end
      S_READ_REQ: begin
        o_stall = 1'b1;
        if (i_mem_ready) state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        o_stall = 1'b1;
        if (i_mem_rvalid) begin
          result_d = i_mem_rdata;
          if (op_q == AMO_LR) begin
            state_d = S_DONE;
          end else begin
            wdata_d = alu_out;
            state_d = S_WRITE_REQ;
          end
        end
      end
      S_WRITE_REQ: begin
        o_stall = 1'b1;
        if (i_mem_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // request fields are zero whenever no request is presented
  assign o_mem_req      = (state_q == S_READ_REQ) || (state_q == S_WRITE_REQ);
  assign o_mem_we       = (state_q == S_WRITE_REQ);
  assign o_mem_addr     = o_mem_req ? {word_q, 2'b00} : '0;
  assign o_mem_wdata    = o_mem_we ? wdata_q : '0;
  assign o_result_valid = (state_q == S_DONE) && !mis_q;
  assign o_misaligned   = (state_q == S_DONE) && mis_q;
  assign o_result       = o_result_valid ? result_q : '0;

endmodule

// File: tb/tb_amo_unit.sv
// Self-checking bench for amo_unit: directed vector table, random atomics
// against a reference model, and hand-written flush / reset-abort sequences.
module tb_amo_unit;
  import riscv_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  amo_op_e      i_op = AMO_LR;
  logic [31:0]  i_addr = '0;
  logic [31:0]  i_rs2_data = '0;
  logic         i_flush = 1'b0;
  reservation_t i_reservation = '0;
  logic         o_mem_req, o_mem_we;
  logic [31:0]  o_mem_addr, o_mem_wdata;
  logic         i_mem_ready = 1'b0;
  logic         i_mem_rvalid = 1'b0;
  logic [31:0]  i_mem_rdata = '0;
  logic         o_stall, o_result_valid, o_misaligned;
  logic [31:0]  o_result;

  int n_cmp = 0;
  int n_bad = 0;

  amo_unit #(.XLEN(32)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .i_op           (i_op),
    .i_addr         (i_addr),
    .i_rs2_data     (i_rs2_data),
    .i_flush        (i_flush),
    .i_reservation  (i_reservation),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_ready    (i_mem_ready),
    .i_mem_rvalid   (i_mem_rvalid),
    .i_mem_rdata    (i_mem_rdata),
    .o_stall        (o_stall),
    .o_result_valid (o_result_valid),
    .o_result       (o_result),
    .o_misaligned   (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string        name;
    amo_op_e      op;
    logic [31:0]  addr;
    logic [31:0]  rs2;
    reservation_t resv;
    logic [31:0]  memv;
    int           rwait;
    logic         exp_mis;
    int           exp_rd;
    int           exp_wr;
    logic [31:0]  exp_wdata;
    logic [31:0]  exp_result;
    int           exp_lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got 0x%h, expected 0x%h", tag, what, act, exp);
    end
  endtask

  function automatic reservation_t mk_resv(logic v, logic [31:0] a, logic lif, logic [31:0] la);
    reservation_t r;
    r.valid = v;
    r.address = a;
    r.lr_in_flight = lif;
    r.lr_in_flight_addr = la;
    return r;
  endfunction

  function automatic vec_t mk(string name, amo_op_e op, logic [31:0] addr, logic [31:0] rs2,
                              reservation_t resv, logic [31:0] memv, int rwait, logic exp_mis,
                              int exp_rd, int exp_wr, logic [31:0] exp_wdata,
                              logic [31:0] exp_result, int exp_lat);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.rs2 = rs2; v.resv = resv; v.memv = memv;
    v.rwait = rwait; v.exp_mis = exp_mis; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    v.exp_wdata = exp_wdata; v.exp_result = exp_result; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Reference read-modify-write written from the ISA rules with plain arithmetic.
  function automatic logic [31:0] ref_f(amo_op_e op, logic [31:0] old, logic [31:0] b);
    int so, sb;
    longint unsigned uo, ub;
    logic [32:0] sum;
    so = old; sb = b; uo = old; ub = b;
    sum = {1'b0, old} + {1'b0, b};
    case (op)
      AMO_SWAP: return b;
      AMO_ADD:  return sum[31:0];
      AMO_XOR:  return old ^ b;
      AMO_AND:  return old & b;
      AMO_OR:   return old | b;
      AMO_MIN:  return (sb < so) ? b : old;
      AMO_MAX:  return (sb > so) ? b : old;
      AMO_MINU: return (ub < uo) ? b : old;
      AMO_MAXU: return (ub > uo) ? b : old;
      default:  return old;
    endcase
  endfunction

  function automatic vec_t model(string name, amo_op_e op, logic [31:0] addr, logic [31:0] rs2,
                                 reservation_t resv, logic [31:0] memv, int rwait);
    logic mis, ok;
    mis = (addr % 4) != 0;
    ok  = (resv.valid && (resv.address / 4 == addr / 4)) ||
          (resv.lr_in_flight && (resv.lr_in_flight_addr / 4 == addr / 4));
    if (mis)
      return mk(name, op, addr, rs2, resv, memv, rwait, 1'b1, 0, 0, 32'h0, 32'h0, 1);
    if (op == AMO_SC && !ok)
      return mk(name, op, addr, rs2, resv, memv, rwait, 1'b0, 0, 0, 32'h0, 32'h1, 1);
    if (op == AMO_SC)
      return mk(name, op, addr, rs2, resv, memv, rwait, 1'b0, 0, 1, rs2, 32'h0, 2 + rwait);
    if (op == AMO_LR)
      return mk(name, op, addr, rs2, resv, memv, rwait, 1'b0, 1, 0, 32'h0, memv, 3 + rwait);
    return mk(name, op, addr, rs2, resv, memv, rwait, 1'b0, 1, 1, ref_f(op, memv, rs2), memv,
              4 + 2 * rwait);
  endfunction

  // Entered #1 after a posedge with the DUT idle; leaves it idle the same way.
  task automatic run_txn(input vec_t v);
    int rd_n, wr_n, lat, stall_n, wcnt;
    logic [31:0] rd_a, wr_a, wr_d, res, prev_a, prev_d;
    logic mis, done, rv_next, pend, prev_we;
    rd_n = 0; wr_n = 0; lat = 0; wcnt = 0; done = 0; rv_next = 0; pend = 0; mis = 0;
    rd_a = '0; wr_a = '0; wr_d = '0; res = '0; prev_a = '0; prev_d = '0; prev_we = 0;
    i_valid = 1'b1; i_op = v.op; i_addr = v.addr; i_rs2_data = v.rs2; i_reservation = v.resv;
    #1;
    stall_n = o_stall ? 1 : 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_mem_ready = 1'b0;
      i_mem_rvalid = rv_next;
      i_mem_rdata = rv_next ? v.memv : 32'h0;
      rv_next = 1'b0;
      if (o_result_valid || o_misaligned) begin
        done = 1'b1; lat = c; res = o_result; mis = o_misaligned;
      end
      if (o_mem_req) begin
        if (pend) begin
          chk(v.name, "held addr", o_mem_addr, prev_a);
          chk(v.name, "held we", {31'h0, o_mem_we}, {31'h0, prev_we});
          chk(v.name, "held wdata", o_mem_wdata, prev_d);
        end
        if (wcnt >= v.rwait) begin
          i_mem_ready = 1'b1; wcnt = 0; pend = 1'b0;
          if (o_mem_we) begin
            wr_n++; wr_a = o_mem_addr; wr_d = o_mem_wdata;
          end else begin
            rd_n++; rd_a = o_mem_addr; rv_next = 1'b1;
          end
        end else begin
          wcnt++; pend = 1'b1; prev_a = o_mem_addr; prev_we = o_mem_we; prev_d = o_mem_wdata;
        end
      end
      #1;
      if (o_stall) stall_n++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got no completion, expected one within 60 cycles", v.name);
    end
    chk(v.name, "latency", lat, v.exp_lat);
    chk(v.name, "misaligned", {31'h0, mis}, {31'h0, v.exp_mis});
    chk(v.name, "result", res, v.exp_result);
    chk(v.name, "stall cycles", stall_n, v.exp_lat);
    chk(v.name, "reads", rd_n, v.exp_rd);
    chk(v.name, "writes", wr_n, v.exp_wr);
    if (v.exp_rd > 0) chk(v.name, "read addr", rd_a, {v.addr[31:2], 2'b00});
    if (v.exp_wr > 0) begin
      chk(v.name, "write addr", wr_a, {v.addr[31:2], 2'b00});
      chk(v.name, "write data", wr_d, v.exp_wdata);
    end
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_reservation = '0;
    @(posedge i_clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, "mem_req", {31'h0, o_mem_req}, 32'h0);
    chk(tag, "mem_we", {31'h0, o_mem_we}, 32'h0);
    chk(tag, "mem_addr", o_mem_addr, 32'h0);
    chk(tag, "mem_wdata", o_mem_wdata, 32'h0);
    chk(tag, "stall", {31'h0, o_stall}, 32'h0);
    chk(tag, "result_valid", {31'h0, o_result_valid}, 32'h0);
    chk(tag, "result", o_result, 32'h0);
    chk(tag, "misaligned", {31'h0, o_misaligned}, 32'h0);
  endtask

  initial begin
    reservation_t r0, r100, r104, rlif;
    r0   = mk_resv(1'b0, 32'h0, 1'b0, 32'h0);
    r100 = mk_resv(1'b1, 32'h100, 1'b0, 32'h0);
    r104 = mk_resv(1'b1, 32'h104, 1'b0, 32'h0);
    rlif = mk_resv(1'b0, 32'h0, 1'b1, 32'h100);

    //            name        op        addr        rs2          resv  mem          w mis rd wr wdata        result       lat
    tbl.push_back(mk("lr",      AMO_LR,   32'h100, 32'h0,        r0,   32'hDEADBEEF, 0, 0, 1, 0, 32'h0,        32'hDEADBEEF, 3));
    tbl.push_back(mk("sc_ok",   AMO_SC,   32'h100, 32'h55,       r100, 32'h0,        0, 0, 0, 1, 32'h55,       32'h0,        2));
    tbl.push_back(mk("sc_fail", AMO_SC,   32'h100, 32'h55,       r104, 32'h0,        0, 0, 0, 0, 32'h0,        32'h1,        1));
    tbl.push_back(mk("sc_lif",  AMO_SC,   32'h100, 32'h77,       rlif, 32'h0,        0, 0, 0, 1, 32'h77,       32'h0,        2));
    tbl.push_back(mk("min",     AMO_MIN,  32'h200, 32'h1,        r0,   32'hFFFFFFFF, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4));
    tbl.push_back(mk("minu",    AMO_MINU, 32'h200, 32'h1,        r0,   32'hFFFFFFFF, 0, 0, 1, 1, 32'h1,        32'hFFFFFFFF, 4));
    tbl.push_back(mk("add_wrap",AMO_ADD,  32'h204, 32'h2,        r0,   32'hFFFFFFFF, 0, 0, 1, 1, 32'h1,        32'hFFFFFFFF, 4));
    tbl.push_back(mk("swap_mis",AMO_SWAP, 32'h102, 32'h9,        r0,   32'h0,        0, 1, 0, 0, 32'h0,        32'h0,        1));
    tbl.push_back(mk("sc_mis",  AMO_SC,   32'h103, 32'h9,        r100, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0,        1));
    tbl.push_back(mk("max",     AMO_MAX,  32'h300, 32'h5,        r0,   32'h80000000, 0, 0, 1, 1, 32'h5,        32'h80000000, 4));
    tbl.push_back(mk("maxu",    AMO_MAXU, 32'h300, 32'h5,        r0,   32'h80000000, 0, 0, 1, 1, 32'h80000000, 32'h80000000, 4));
    tbl.push_back(mk("xor",     AMO_XOR,  32'h310, 32'hFF,       r0,   32'h0000F0F0, 0, 0, 1, 1, 32'h0000F00F, 32'h0000F0F0, 4));
    tbl.push_back(mk("and",     AMO_AND,  32'h314, 32'hFF,       r0,   32'h0000F0F0, 1, 0, 1, 1, 32'h000000F0, 32'h0000F0F0, 6));
    tbl.push_back(mk("or",      AMO_OR,   32'h318, 32'hFF,       r0,   32'h0000F0F0, 2, 0, 1, 1, 32'h0000F0FF, 32'h0000F0F0, 8));
    tbl.push_back(mk("min_tie", AMO_MIN,  32'h31C, 32'h7,        r0,   32'h7,        0, 0, 1, 1, 32'h7,        32'h7,        4));
    tbl.push_back(mk("swap",    AMO_SWAP, 32'h320, 32'hCAFE0001, r0,   32'h12345678, 3, 0, 1, 1, 32'hCAFE0001, 32'h12345678, 10));

    #3;
    chk_quiet("reset");
    #20 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk_quiet("post_reset");

    for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i]);

    // flush in IDLE blocks the start entirely
    i_valid = 1'b1; i_flush = 1'b1; i_op = AMO_LR; i_addr = 32'h40;
    #1;
    chk("flush", "stall", {31'h0, o_stall}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      chk("flush", "mem_req", {31'h0, o_mem_req}, 32'h0);
      chk("flush", "result_valid", {31'h0, o_result_valid}, 32'h0);
    end
    i_valid = 1'b0; i_flush = 1'b0;

    // random atomics against the reference model
    for (int i = 0; i < 60; i++) begin
      amo_op_e op;
      logic [31:0] addr, other;
      reservation_t r;
      op = amo_op_e'($urandom_range(0, 10));
      addr = {18'h0, $urandom_range(0, 255), 6'h0} + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      other = addr ^ 32'h4;
      r.valid = $urandom_range(0, 1);
      r.address = $urandom_range(0, 1) ? (addr ^ $urandom_range(0, 3)) : other;
      r.lr_in_flight = $urandom_range(0, 1);
      r.lr_in_flight_addr = $urandom_range(0, 1) ? addr : other;
      run_txn(model($sformatf("rnd%0d", i), op, addr, $urandom, r, $urandom, $urandom_range(0, 2)));
    end

    // AMOADD: read held for 3 cycles, then reset while the write is pending
    i_valid = 1'b1; i_op = AMO_ADD; i_addr = 32'h200; i_rs2_data = 32'h5;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort", "read req held", {31'h0, o_mem_req}, 32'h1);
      chk("abort", "read addr held", o_mem_addr, 32'h200);
      chk("abort", "read we held", {31'h0, o_mem_we}, 32'h0);
      @(posedge i_clk); #1;
    end
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h10;
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    chk("abort", "write req", {31'h0, o_mem_req & o_mem_we}, 32'h1);
    chk("abort", "write data", o_mem_wdata, 32'h15);
    #2 i_rst_n = 1'b0;
    #1;
    chk_quiet("abort_in_reset");
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("abort", "no write while ready", {31'h0, o_mem_req}, 32'h0);
    i_mem_ready = 1'b0;
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk_quiet("abort_released");

    run_txn(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/amo_unit.md
# amo_unit

Atomic memory sequencer for the RISC-V A extension: executes LR.W, SC.W and the nine AMO*.W read-modify-write operations against the data-memory port. It sits in EX/MA next to `lr_sc_reservation`, consumes its `riscv_pkg::reservation_t` output to decide SC.W success, and stalls the pipeline until the atomic completes. The reservation is cleared by `lr_sc_reservation` itself when the SC.W is in EX; this block only reads it.

## Interface
- `XLEN`, 32, data/address width.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  atomic instruction present in EX.
- `i_op`  in  `riscv_pkg::amo_op_e`  LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU.
- `i_addr`  in  XLEN  effective address (rs1).
- `i_rs2_data`  in  XLEN  store/operand data.
- `i_flush`  in  1  pipeline flush; blocks a start from IDLE only.
- `i_reservation`  in  `riscv_pkg::reservation_t`  from `lr_sc_reservation`.
- `o_mem_req`  out  1  memory request valid.
- `o_mem_we`  out  1  1 = write, 0 = read.
- `o_mem_addr`  out  XLEN  word-aligned address.
- `o_mem_wdata`  out  XLEN  write data.
- `i_mem_ready`  in  1  request accepted this cycle.
- `i_mem_rvalid`  in  1  read data valid.
- `i_mem_rdata`  in  XLEN  read data.
- `o_stall`  out  1  hold pipeline.
- `o_result_valid`  out  1  rd result valid (one cycle).
- `o_result`  out  XLEN  value written to rd.
- `o_misaligned`  out  1  address-misaligned exception (one cycle).

## Operation
- States: IDLE, READ_REQ, READ_WAIT, WRITE_REQ, DONE.
- IDLE: on `i_valid && !i_flush`, latch op/addr/rs2 and branch:
  - `i_addr[1:0] != 0` → DONE with `o_misaligned=1`, no memory access, `o_result=0`.
  - LR or AMO → READ_REQ.
  - SC: success = (`valid` && `address[XLEN-1:2]==i_addr[XLEN-1:2]`) || (`lr_in_flight` && `lr_in_flight_addr[XLEN-1:2]==i_addr[XLEN-1:2]`). Success → WRITE_REQ with wdata=rs2, result 0. Fail → DONE, result 1, no memory access.
- READ_REQ: `o_mem_req=1, o_mem_we=0`; on `i_mem_ready` → READ_WAIT.
- READ_WAIT: on `i_mem_rvalid`, capture rdata as old value; LR → DONE (result=rdata); AMO → WRITE_REQ with wdata=f(op, old, rs2).
- WRITE_REQ: `o_mem_req=1, o_mem_we=1`; on `i_mem_ready` → DONE (writes are posted). AMO result = old value.
- DONE: `o_result_valid=1` (or `o_misaligned=1`), `o_stall=0`, → IDLE.
- f: SWAP=rs2; ADD wraps mod 2^XLEN; XOR/AND/OR bitwise; MIN/MAX signed compare; MINU/MAXU unsigned; ties return old.
- `i_flush` ignored outside IDLE: a started atomic always completes.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; latched regs 0. Reset mid-transaction drops `o_mem_req` immediately; no write is issued.
- `o_stall = (state==IDLE && i_valid && !i_flush) || state ∈ {READ_REQ, READ_WAIT, WRITE_REQ}` (combinational from state and inputs).
- Request addr/we/wdata stable while `o_mem_req && !i_mem_ready`.
- `i_mem_rvalid` earliest the cycle after read acceptance; rvalid in READ_REQ or IDLE is ignored.
- Zero-wait memory latencies from IDLE-accept cycle N: SC-fail/misaligned result at N+1; SC-success N+2; LR N+3; AMO N+4.
- Back-to-back atomics: new start accepted in the IDLE cycle after DONE.

## Structure
- `riscv_pkg`: `amo_op_e`, `reservation_t` (existing).
- Local state enum in module.
- Sub-module `amo_alu` (combinational f(op, old, rs2)).

## Test plan
- LR.W 0x100 (rdata 0xDEADBEEF, ready=1, rvalid next cycle) → one read at 0x100, result 0xDEADBEEF at N+3, stall high N..N+2.
- SC.W 0x100, reservation valid@0x100, rs2=0x55 → write 0x55 to 0x100, result 0 at N+2; same with reservation addr 0x104 → no mem req, result 1 at N+1.
- SC.W with `valid=0`, `lr_in_flight=1`, `lr_in_flight_addr=0x100` → success, result 0.
- AMOMIN.W old 0xFFFFFFFF, rs2 1 → writes 0xFFFFFFFF, result 0xFFFFFFFF; AMOMINU same → writes 1; AMOADD old 0xFFFFFFFF rs2 2 → writes 1.
- AMOSWAP 0x102 → o_misaligned at N+1, no o_mem_req ever.
- AMOADD with `i_mem_ready` low 3 cycles in READ_REQ, then `i_rst_n` low in WRITE_REQ → request held stable while stalled; after reset outputs 0, state IDLE, no write accepted.
